// File: rtl/act_unpacker.sv
// act_unpacker: reads 32-bit buffer words holding four offset-128 uint8
// activations and streams them out as signed int8 bytes, one per valid/ready
// transfer. It also issues the word read addresses for a programmed byte count.
module act_unpacker #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_act,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [7:0]        data_out,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [31:0]       word_q;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  remain;
    logic [ADDR_W-1:0] addr_q;

    logic              transfer;
    logic              last_byte;
    logic [7:0]        word_bytes [4];

    // A byte leaves only while presenting it and the consumer accepts.
    assign transfer  = (state_reg == S_EMIT) && ready;
    // remain is at least 1 throughout EMIT, so this is the job's final byte.
    assign last_byte = (remain == CNT_W'(1));

    // Convert each stored byte from offset-128 to two's complement.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign word_bytes[gi] = word_q[8*gi +: 8] ^ 8'h80;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a transfer of the final byte ends the job even mid-word.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_act != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_EMIT;
            S_EMIT: begin
                if (transfer) begin
                    if (last_byte) begin
                        state_next = S_DONE;
                    end else if (idx == 2'd3) begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: job parameters, word capture, byte index and remaining count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx    <= '0;
            remain <= '0;
            addr_q <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        remain <= num_act;
                        addr_q <= base_addr;
                    end
                end
                S_WAIT: begin
                    // Read data arrives one cycle after the FETCH request.
                    word_q <= rd_data;
                    idx    <= 2'd0;
                    addr_q <= addr_q + ADDR_W'(1);
                end
                S_EMIT: begin
                    if (transfer) begin
                        remain <= remain - CNT_W'(1);
                        idx    <= idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The address is only meaningful while rd_en is high.
    assign rd_addr = addr_q;

    // Output decode from the state register only; nothing depends on ready.
    always_comb begin
        rd_en    = 1'b0;
        valid    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        data_out = 8'h00;
        case (state_reg)
            S_IDLE:  busy = 1'b0;
            S_FETCH: rd_en = 1'b1;
            S_EMIT: begin
                valid    = 1'b1;
                data_out = word_bytes[idx];
            end
            S_DONE:  done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
